// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit -- instruction fetch stage of the RV32IM pipeline.
//
// Walks a sequential PC and issues pipelined reads on the instruction-memory
// req/gnt/rvalid bus. Returned words go into a small in-order FIFO, and the
// FIFO head is presented to decode with a static not-taken prediction.
//
// Ports:
//   clk_i, arstn_i         clock, asynchronous active-low reset
//   cu_force_pc_i          redirect target (low two bits ignored)
//   cu_force_f_i           redirect strobe
//   cu_kill_f_i            flush; also redirects to cu_force_pc_i
//   cu_stall_f_i           decode cannot take the head this cycle
//   instr_req_o/addr_o     memory request, word-aligned address
//   instr_gnt_i            request accepted this cycle
//   instr_rvalid_i/rdata_i in-order read response (never backpressured)
//   f_instr_o, f_current_pc_o, f_next_pc_o, f_prediction_o, f_valid_o
//                          head of the instruction buffer toward decode
module rv_fetch_unit #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic [XLEN-1:0] cu_force_pc_i,
   input  logic            cu_force_f_i,
   input  logic            cu_stall_f_i,
   input  logic            cu_kill_f_i,
   output logic            instr_req_o,
   output logic [XLEN-1:0] instr_addr_o,
   input  logic            instr_gnt_i,
   input  logic            instr_rvalid_i,
   input  logic [31:0]     instr_rdata_i,
   output logic [31:0]     f_instr_o,
   output logic [XLEN-1:0] f_current_pc_o,
   output logic [XLEN-1:0] f_next_pc_o,
   output logic            f_prediction_o,
   output logic            f_valid_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int SUM_W = CNT_W + 1;

   logic [XLEN-1:0]  req_pc_q, req_pc_d, resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [CNT_W-1:0] outst_q, outst_d;    // granted, response still owed
   logic [CNT_W-1:0] disc_q, disc_d;      // owed responses to throw away
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [XLEN-1:0]  pc_mem_q    [FIFO_DEPTH];
   logic [31:0]      instr_mem_q [FIFO_DEPTH];
   logic [XLEN-1:0]  hold_pc_q, hold_pc_d;
   logic [31:0]      hold_instr_q, hold_instr_d;

   logic             force_w, accept, push, drop, pop;
   logic [SUM_W-1:0] budget;
   logic [XLEN-1:0]  target;

   assign force_w = cu_force_f_i | cu_kill_f_i;
   assign target  = cu_force_pc_i & ~XLEN'(3);

   // Every slot is reserved at request time, so a response always has room.
   assign budget      = SUM_W'(outst_q) + SUM_W'(disc_q) + SUM_W'(fifo_cnt_q);
   assign instr_req_o = ~force_w & (budget < SUM_W'(FIFO_DEPTH));
   assign instr_addr_o = req_pc_q;

   assign accept = instr_req_o & instr_gnt_i;
   assign push   = instr_rvalid_i & ~force_w & (disc_q == '0);
   assign drop   = instr_rvalid_i & ~force_w & (disc_q != '0);

   assign f_valid_o      = (fifo_cnt_q != '0);
   assign pop            = f_valid_o & ~cu_stall_f_i & ~force_w;
   // Empty FIFO shows the last head seen; decode qualifies with f_valid_o.
   assign f_instr_o      = f_valid_o ? instr_mem_q[rptr_q] : hold_instr_q;
   assign f_current_pc_o = f_valid_o ? pc_mem_q[rptr_q]    : hold_pc_q;
   assign f_next_pc_o    = f_current_pc_o + XLEN'(4);
   assign f_prediction_o = 1'b0;

   always_comb begin
      req_pc_d     = req_pc_q;
      resp_pc_d    = resp_pc_q;
      fifo_cnt_d   = fifo_cnt_q;
      outst_d      = outst_q;
      disc_d       = disc_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      hold_pc_d    = f_current_pc_o;
      hold_instr_d = f_instr_o;
      if (force_w) begin
         // All owed responses become junk; one arriving now is already dropped.
         req_pc_d   = target;
         resp_pc_d  = target;
         fifo_cnt_d = '0;
         wptr_d     = '0;
         rptr_d     = '0;
         outst_d    = '0;
         disc_d     = outst_q + disc_q - CNT_W'(instr_rvalid_i);
      end else begin
         if (accept) req_pc_d = req_pc_q + XLEN'(4);
         if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
            wptr_d    = wptr_q + PTR_W'(1);
         end
         if (pop) rptr_d = rptr_q + PTR_W'(1);
         outst_d    = outst_q + CNT_W'(accept) - CNT_W'(push);
         disc_d     = disc_q - CNT_W'(drop);
         fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         req_pc_q     <= '0;
         resp_pc_q    <= '0;
         fifo_cnt_q   <= '0;
         outst_q      <= '0;
         disc_q       <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         hold_pc_q    <= '0;
         hold_instr_q <= '0;
      end else begin
         req_pc_q     <= req_pc_d;
         resp_pc_q    <= resp_pc_d;
         fifo_cnt_q   <= fifo_cnt_d;
         outst_q      <= outst_d;
         disc_q       <= disc_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   // Storage is only read while occupied, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[wptr_q]    <= resp_pc_q;
         instr_mem_q[wptr_q] <= instr_rdata_i;
      end
   end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Testbench for rv_fetch_unit: directed boot/stall/redirect/wrap scenarios
// followed by a long randomized run. The memory is a latency queue, and
// decode-side expectations come from a stream model: after a redirect to T,
// decode must consume T, T+4, T+8, ... each carrying the memory word at that
// address.
module tb_rv_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic [31:0] cu_force_pc_i;
   logic        cu_force_f_i, cu_stall_f_i, cu_kill_f_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i, instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic [31:0] f_instr_o, f_current_pc_o, f_next_pc_o;
   logic        f_prediction_o, f_valid_o;

   rv_fetch_unit #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .arstn_i(arstn_i),
      .cu_force_pc_i(cu_force_pc_i), .cu_force_f_i(cu_force_f_i),
      .cu_stall_f_i(cu_stall_f_i), .cu_kill_f_i(cu_kill_f_i),
      .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
      .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i),
      .f_instr_o(f_instr_o), .f_current_pc_o(f_current_pc_o),
      .f_next_pc_o(f_next_pc_o), .f_prediction_o(f_prediction_o),
      .f_valid_o(f_valid_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      int          rdy;
   } mreq_t;

   mreq_t       mq[$];
   int          cyc, lat_lo, lat_hi, gnt_pct;
   logic [31:0] exp_pc;
   int          n_chk, n_fail;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Drive memory inputs for this cycle, then wait to mid-cycle.
   task automatic cyc_begin();
      instr_gnt_i = ($urandom_range(99) < gnt_pct);
      if (mq.size() > 0 && mq[0].rdy <= cyc) begin
         instr_rvalid_i = 1'b1;
         instr_rdata_i  = mem_word(mq[0].addr);
      end else begin
         instr_rvalid_i = 1'b0;
         instr_rdata_i  = $urandom;
      end
      @(negedge clk_i);
   endtask

   // Check the decode stream, update memory and model, advance a cycle.
   task automatic cyc_end();
      logic frc;
      frc = cu_force_f_i | cu_kill_f_i;
      if (frc) chk("req_in_force", {31'd0, instr_req_o}, 32'd0);
      if (mq.size() >= DEPTH) chk("req_when_full", {31'd0, instr_req_o}, 32'd0);
      if (instr_req_o) chk("addr_align", {30'd0, instr_addr_o[1:0]}, 32'd0);
      if (f_valid_o && !cu_stall_f_i && !frc) begin
         chk("head_pc", f_current_pc_o, exp_pc);
         chk("head_instr", f_instr_o, mem_word(exp_pc));
         chk("next_pc", f_next_pc_o, exp_pc + 32'd4);
         chk("prediction", {31'd0, f_prediction_o}, 32'd0);
         exp_pc = exp_pc + 32'd4;
      end
      if (instr_rvalid_i) void'(mq.pop_front());
      if (instr_req_o && instr_gnt_i)
         mq.push_back('{addr: instr_addr_o, rdy: cyc + int'($urandom_range(lat_hi, lat_lo))});
      chk("inflight_cap", {31'd0, (mq.size() <= DEPTH)}, 32'd1);
      if (frc) exp_pc = cu_force_pc_i & ~32'd3;
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic tick();
      cyc_begin();
      cyc_end();
   endtask

   task automatic do_reset();
      arstn_i        = 1'b0;
      cu_force_f_i   = 1'b1;
      cu_force_pc_i  = 32'h8000_0000;
      cu_kill_f_i    = 1'b0;
      cu_stall_f_i   = 1'b0;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      #1;
      chk("rst_valid", {31'd0, f_valid_o}, 32'd0);
      chk("rst_req", {31'd0, instr_req_o}, 32'd0);
      chk("rst_addr", instr_addr_o, 32'd0);
      chk("rst_instr", f_instr_o, 32'd0);
      chk("rst_pc", f_current_pc_o, 32'd0);
      chk("rst_next_pc", f_next_pc_o, 32'd4);
      chk("rst_pred", {31'd0, f_prediction_o}, 32'd0);
      mq.delete();
      exp_pc = 32'd0;
      repeat (2) @(posedge clk_i);
      #1;
      arstn_i = 1'b1;
   endtask

   // Hold a kill-redirect long enough that every owed response has drained.
   task automatic flush(input int n, input logic [31:0] tgt);
      cu_kill_f_i   = 1'b1;
      cu_force_f_i  = 1'b1;
      cu_force_pc_i = tgt;
      repeat (n) tick();
      cu_kill_f_i  = 1'b0;
      cu_force_f_i = 1'b0;
   endtask

   // Leaves the caller at mid-cycle with f_valid_o high when ok is set.
   task automatic wait_head(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         cyc_begin();
         if (f_valid_o) begin
            ok = 1'b1;
            return;
         end
         cyc_end();
      end
   endtask

   initial begin
      logic [31:0] pc0;
      bit ok;
      n_chk = 0; n_fail = 0; cyc = 0;
      lat_lo = 1; lat_hi = 1; gnt_pct = 100;
      instr_rdata_i = '0;
      do_reset();

      // Boot: force held for two cycles after reset release.
      tick(); tick();
      cu_force_f_i = 1'b0;
      cyc_begin();
      chk("boot_req", {31'd0, instr_req_o}, 32'd1);
      chk("boot_addr", instr_addr_o, 32'h8000_0000);
      cyc_end();
      tick();
      cyc_begin();
      chk("boot_valid", {31'd0, f_valid_o}, 32'd1);
      chk("boot_pc0", f_current_pc_o, 32'h8000_0000);
      cyc_end();
      cyc_begin();
      chk("boot_pc1", f_current_pc_o, 32'h8000_0004);
      cyc_end();
      repeat (4) tick();

      // Stall: buffer fills, requests stop, head stays put.
      cu_stall_f_i = 1'b1;
      tick();
      cyc_begin();
      pc0 = f_current_pc_o;
      cyc_end();
      tick(); tick();
      cyc_begin();
      chk("stall_valid", {31'd0, f_valid_o}, 32'd1);
      chk("stall_req", {31'd0, instr_req_o}, 32'd0);
      chk("stall_pc", f_current_pc_o, pc0);
      cyc_end();
      cu_stall_f_i = 1'b0;
      repeat (6) tick();

      // Mispredict with two requests outstanding.
      lat_lo = 4; lat_hi = 4;
      flush(8, 32'h8000_0040);
      tick(); tick();
      cu_kill_f_i = 1'b1; cu_force_f_i = 1'b1; cu_force_pc_i = 32'h8000_0100;
      tick();
      cu_kill_f_i = 1'b0; cu_force_f_i = 1'b0;
      wait_head(30, ok);
      chk("kill_head_seen", {31'd0, ok}, 32'd1);
      if (ok) begin
         chk("kill_head_pc", f_current_pc_o, 32'h8000_0100);
         chk("kill_head_instr", f_instr_o, mem_word(32'h8000_0100));
         cyc_end();
      end
      repeat (4) tick();

      // Response lands in the force cycle with two outstanding.
      lat_lo = 2; lat_hi = 2;
      flush(8, 32'h8000_0180);
      tick(); tick();
      cu_force_f_i = 1'b1; cu_force_pc_i = 32'h8000_0200;
      tick();
      cu_force_f_i = 1'b0;
      wait_head(30, ok);
      chk("simul_head_seen", {31'd0, ok}, 32'd1);
      if (ok) begin
         chk("simul_head_pc", f_current_pc_o, 32'h8000_0200);
         cyc_end();
      end
      repeat (4) tick();

      // Address wrap and alignment.
      lat_lo = 1; lat_hi = 1;
      flush(6, 32'hFFFF_FFFE);
      cyc_begin();
      chk("wrap_addr0", instr_addr_o, 32'hFFFF_FFFC);
      chk("wrap_req0", {31'd0, instr_req_o}, 32'd1);
      cyc_end();
      cyc_begin();
      chk("wrap_addr1", instr_addr_o, 32'h0000_0000);
      cyc_end();
      wait_head(10, ok);
      chk("wrap_head_seen", {31'd0, ok}, 32'd1);
      if (ok) begin
         chk("wrap_head_pc", f_current_pc_o, 32'hFFFF_FFFC);
         chk("wrap_next_pc", f_next_pc_o, 32'h0000_0000);
         cyc_end();
      end

      // Randomized traffic with stalls, kills, redirects and one reset.
      lat_lo = 1; lat_hi = 4; gnt_pct = 75;
      for (int i = 0; i < 10000; i++) begin
         cu_stall_f_i = ($urandom_range(99) < 25);
         cu_kill_f_i  = ($urandom_range(99) < 2);
         cu_force_f_i = ($urandom_range(99) < 2);
         cu_force_pc_i = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                  : $urandom;
         if (i == 5000) begin
            cyc_begin();
            do_reset();
         end else begin
            tick();
         end
      end
      cu_stall_f_i = 1'b0; cu_kill_f_i = 1'b0; cu_force_f_i = 1'b0;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
